// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - running-minimum SAD tracker for block motion search
//
// Purpose: consumes one column-minimum SAD per beat from the compare tree,
// keeps the best (SAD, column, row) across NUM_COL columns and presents the
// block result on a valid/ready output.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request to begin (or restart) a block search
//   in_valid, in_ready  per-column result handshake (in_ready only in SEARCH)
//   in_sad, in_mv_y     column-minimum SAD and its row index
//   sad_min_pre         registered running minimum, fed back to the compare tree
//   out_valid, out_ready  block result handshake
//   out_sad, out_mv_x, out_mv_y  best SAD, its column and its row
//   busy                high whenever the FSM is not IDLE
//
// Optional feature: define SAD_MIN_EARLY_TERM_EN to end the search on the
// first beat whose SAD is zero (nothing can beat it).

module sad_min_tracker #(
  parameter int SAD_W   = 14,
  parameter int MV_W    = 4,
  parameter int NUM_COL = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SAD_W-1:0] in_sad,
  input  logic [MV_W-1:0]  in_mv_y,
  output logic [SAD_W-1:0] sad_min_pre,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAD_W-1:0] out_sad,
  output logic [MV_W-1:0]  out_mv_x,
  output logic [MV_W-1:0]  out_mv_y,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [MV_W-1:0]  COL_ONE  = MV_W'(1);
  localparam logic [MV_W-1:0]  COL_LAST = MV_W'(NUM_COL - 1);
  localparam logic [SAD_W-1:0] SAD_INIT = '1;

  logic [1:0]       state;
  logic [MV_W-1:0]  col;
  logic [SAD_W-1:0] best_sad;
  logic [MV_W-1:0]  best_x;
  logic [MV_W-1:0]  best_y;

  logic             beat;
  logic             take;
  logic             last;
  logic [SAD_W-1:0] nxt_sad;
  logic [MV_W-1:0]  nxt_x;
  logic [MV_W-1:0]  nxt_y;

  assign in_ready    = (state == S_SEARCH);
  assign busy        = (state != S_IDLE);
  assign sad_min_pre = best_sad;

  // A start in SEARCH restarts the block, so a coincident beat is dropped.
  assign beat = in_valid && in_ready && !start;

  // Strict compare: on a tie the earlier column is kept.
  assign take    = (in_sad < best_sad);
  assign nxt_sad = take ? in_sad  : best_sad;
  assign nxt_x   = take ? col     : best_x;
  assign nxt_y   = take ? in_mv_y : best_y;

`ifdef SAD_MIN_EARLY_TERM_EN
  assign last = (col == COL_LAST) || (in_sad == '0);
`else
  assign last = (col == COL_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      col       <= '0;
      best_sad  <= SAD_INIT;
      best_x    <= '0;
      best_y    <= '0;
      out_valid <= 1'b0;
      out_sad   <= '0;
      out_mv_x  <= '0;
      out_mv_y  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SEARCH;
            col      <= '0;
            best_sad <= SAD_INIT;
            best_x   <= '0;
            best_y   <= '0;
          end
        end
        S_SEARCH: begin
          if (start) begin
            col      <= '0;
            best_sad <= SAD_INIT;
            best_x   <= '0;
            best_y   <= '0;
          end else if (beat) begin
            best_sad <= nxt_sad;
            best_x   <= nxt_x;
            best_y   <= nxt_y;
            if (last) begin
              // The final beat is already folded into nxt_*; col is left
              // where it stopped instead of wrapping.
              state     <= S_DONE;
              out_valid <= 1'b1;
              out_sad   <= nxt_sad;
              out_mv_x  <= nxt_x;
              out_mv_y  <= nxt_y;
            end else begin
              col <= col + COL_ONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// tb/tb_sad_min_tracker.sv - self-checking bench for sad_min_tracker

module tb_sad_min_tracker;

  localparam int SAD_W   = 14;
  localparam int MV_W    = 4;
  localparam int NUM_COL = 16;
  localparam int ALL1    = (1 << SAD_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [SAD_W-1:0] in_sad;
  logic [MV_W-1:0]  in_mv_y;
  logic [SAD_W-1:0] sad_min_pre;
  logic             out_valid;
  logic             out_ready;
  logic [SAD_W-1:0] out_sad;
  logic [MV_W-1:0]  out_mv_x;
  logic [MV_W-1:0]  out_mv_y;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  int sad_v[NUM_COL];
  int y_v[NUM_COL];

  typedef struct {
    int base;
    int step;
    int y_const;   // -1: row index equals column
    int zero_at;   // -1: none, else column forced to SAD 0
    int e_sad;
    int e_x;
    int e_y;
  } vec_t;

  vec_t tbl[6];

  sad_min_tracker #(.SAD_W(SAD_W), .MV_W(MV_W), .NUM_COL(NUM_COL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_sad(in_sad), .in_mv_y(in_mv_y),
    .sad_min_pre(sad_min_pre), .out_valid(out_valid), .out_ready(out_ready),
    .out_sad(out_sad), .out_mv_x(out_mv_x), .out_mv_y(out_mv_y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Index of the beat that ends the search.
  function automatic int last_idx();
    int stop = NUM_COL - 1;
`ifdef SAD_MIN_EARLY_TERM_EN
    for (int i = NUM_COL - 1; i >= 0; i--) if (sad_v[i] == 0) stop = i;
`endif
    return stop;
  endfunction

  // Reference: first index holding the strict minimum; all-ones never wins
  // against the all-ones starting value.
  function automatic void model(output int es, output int ex, output int ey);
    int stop = last_idx();
    es = ALL1; ex = 0; ey = 0;
    for (int i = 0; i <= stop; i++)
      if (sad_v[i] < es) begin es = sad_v[i]; ex = i; ey = y_v[i]; end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sad"}, out_sad, 0);
    check({tag, "_out_mv_x"}, out_mv_x, 0);
    check({tag, "_out_mv_y"}, out_mv_y, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sad_min_pre"}, sad_min_pre, ALL1);
  endtask

  // One full block: start, beats (with optional idle gaps), DONE hold, handshake.
  task automatic run_search(input int e_sad, input int e_x, input int e_y,
                            input int gap_max, input int hold_n,
                            input bit poke, input bit dirty_start);
    int stop = last_idx();
    int runmin = ALL1;
    start = 1'b1;
    if (dirty_start) begin in_valid = 1'b1; in_sad = '0; end
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("search_busy", busy, 1);
    check("search_in_ready", in_ready, 1);
    check("search_pre_init", sad_min_pre, ALL1);
    for (int i = 0; i <= stop; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0; in_sad = SAD_W'($urandom); tick();
      end
      in_valid = 1'b1; in_sad = SAD_W'(sad_v[i]); in_mv_y = MV_W'(y_v[i]);
      tick();
      in_valid = 1'b0;
      if (sad_v[i] < runmin) runmin = sad_v[i];
      check("sad_min_pre", sad_min_pre, runmin);
      check("out_valid_timing", out_valid, (i == stop));
    end
    check("out_sad", out_sad, e_sad);
    check("out_mv_x", out_mv_x, e_x);
    check("out_mv_y", out_mv_y, e_y);
    out_ready = 1'b0;
    for (int k = 0; k < hold_n; k++) begin
      if (poke) begin start = k[0]; in_valid = 1'b1; in_sad = '0; end
      tick();
      start = 1'b0; in_valid = 1'b0;
      check("hold_out_valid", out_valid, 1);
      check("hold_out_sad", out_sad, e_sad);
      check("hold_out_mv_x", out_mv_x, e_x);
      check("hold_out_mv_y", out_mv_y, e_y);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("accept_busy", busy, 0);
    check("accept_out_valid", out_valid, 0);
  endtask

  initial begin
    int es, ex, ey;
    tbl[0] = '{100, -1, -1, -1, 85, 15, 15};
    tbl[1] = '{50, 0, 3, -1, 50, 0, 3};
    tbl[2] = '{200, 1, -1, -1, 200, 0, 0};
    tbl[3] = '{100, 0, -1, 4, 0, 4, 4};
    tbl[4] = '{ALL1, 0, 7, -1, ALL1, 0, 0};
    tbl[5] = '{300, 2, 9, 15, 0, 15, 9};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sad = '0; in_mv_y = '0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    // in_valid while IDLE is ignored
    in_valid = 1'b1; in_sad = 5; tick(); tick(); in_valid = 1'b0;
    check("idle_valid_busy", busy, 0);
    check("idle_valid_pre", sad_min_pre, ALL1);

    // Table vectors
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NUM_COL; i++) begin
        sad_v[i] = tbl[t].base + tbl[t].step * i;
        y_v[i]   = (tbl[t].y_const < 0) ? i : tbl[t].y_const;
      end
      if (tbl[t].zero_at >= 0) sad_v[tbl[t].zero_at] = 0;
      run_search(tbl[t].e_sad, tbl[t].e_x, tbl[t].e_y, 0, 1, 0, 0);
    end

    // DONE held 5 cycles with start and in_valid poked
    for (int i = 0; i < NUM_COL; i++) begin sad_v[i] = 100 - i; y_v[i] = i; end
    run_search(85, 15, 15, 0, 5, 1, 0);

    // Abort after 7 beats; restart pulse carries a beat that must be dropped
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_sad = 1; in_mv_y = 2; tick();
      check("abort_busy", busy, 1);
    end
    in_valid = 1'b0;
    run_search(85, 15, 15, 1, 1, 0, 1);

    // Reset dropped mid-search after beat 9
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_sad = SAD_W'(20 + i); in_mv_y = 1; tick();
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("after_reset_out_valid", out_valid, 0);
      check("after_reset_busy", busy, 0);
    end
    in_valid = 1'b0;

    // Randomized blocks against the reference model
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NUM_COL; i++) begin
        sad_v[i] = $urandom_range(0, 40);
        y_v[i]   = $urandom_range(0, NUM_COL - 1);
      end
      model(es, ex, ey);
      run_search(es, ex, ey, 2, $urandom_range(0, 3), 1, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
